ncl_ring_tap: RTL

Clocked tap that consumes the dual-rail wavefront stream from one NCL ring stage and acts as that stage's downstream completion partner. It samples the asynchronous rails, accepts each DATA/NULL wavefront under a four-phase handshake, returns the completion signal that gates the upstream stage's enable, and delivers decoded bits to synchronous logic through a 2-entry buffer. It also counts wavefronts and flags illegal codes and stalls for ring-behaviour experiments.

---
 rtl/ncl_ring_tap.sv | 121 ++++++++++++
 1 files changed

// File: rtl/ncl_ring_tap.sv
// ncl_ring_tap: clocked completion partner for one NCL ring stage, decoding dual-rail wavefronts into a 2-entry FIFO.
// Define NCL_TAP_STATS_EN to add period_min/period_max wavefront-period statistics.
module ncl_ring_tap #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 2,
    parameter int TIMEOUT       = 1024
) (
    input  logic        clk,
    input  logic        init_n,
    input  logic [1:0]  z_in,
    output logic        acomp,
    input  logic        clr,
    output logic        out_bit,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] wf_count,
    output logic        err_illegal,
`ifdef NCL_TAP_STATS_EN
    output logic [15:0] period_min,
    output logic [15:0] period_max,
`endif
    output logic        stall
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int IW = $clog2(TIMEOUT + 1);
    typedef enum logic {WAIT_DATA, WAIT_NULL} state_t;
    state_t state_q, state_d;
    logic [SYNC_STAGES-1:0][1:0] sync_q, sync_d;
    logic [1:0] code, last_q, mem_q, mem_d;
    logic [SW-1:0] stab_q, stab_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [15:0] wf_q, wf_d;
    logic [1:0] cnt_q, cnt_d;
    logic wp_q, wp_d, rp_q, rp_d, acomp_q, acomp_d, err_q, err_d, stall_q, stall_d;
    logic acc, is_data, push, pop;
    assign code    = sync_q[SYNC_STAGES-1];
    assign is_data = code[0] ^ code[1];
    assign pop     = out_valid & out_ready;
    // A code is accepted while it has stayed unchanged for STABLE_CYCLES synchronized samples.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], z_in};
        stab_d  = (code != last_q) ? SW'(1) : (stab_q == SW'(STABLE_CYCLES)) ? stab_q : stab_q + 1'b1;
        acc     = stab_d == SW'(STABLE_CYCLES);
        push    = state_q == WAIT_DATA && acc && is_data && (cnt_q != 2'd2 || pop);
        state_d = push ? WAIT_NULL : (state_q == WAIT_NULL && acc && code == 2'b00) ? WAIT_DATA : state_q;
        acomp_d = state_d == WAIT_NULL;
        mem_d   = mem_q;
        if (push) mem_d[wp_q] = code[1];
        wp_d    = wp_q ^ push;
        rp_d    = rp_q ^ pop;
        cnt_d   = cnt_q + {1'b0, push} - {1'b0, pop};
        wf_d    = clr ? 16'd0 : (push && wf_q != 16'hFFFF) ? wf_q + 16'd1 : wf_q;
        err_d   = clr ? 1'b0 : err_q | (acc & (&code));
        idle_d  = (clr || state_d != state_q) ? '0 : (idle_q == IW'(TIMEOUT)) ? idle_q : idle_q + 1'b1;
        stall_d = clr ? 1'b0 : stall_q | (idle_d == IW'(TIMEOUT));
    end
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            sync_q  <= '0;
            last_q  <= 2'b00;
            stab_q  <= '0;
            state_q <= WAIT_DATA;
            acomp_q <= 1'b0;
            mem_q   <= 2'b00;
            wp_q    <= 1'b0;
            rp_q    <= 1'b0;
            cnt_q   <= 2'd0;
            wf_q    <= 16'd0;
            err_q   <= 1'b0;
            idle_q  <= '0;
            stall_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            last_q  <= code;
            stab_q  <= stab_d;
            state_q <= state_d;
            acomp_q <= acomp_d;
            mem_q   <= mem_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            wf_q    <= wf_d;
            err_q   <= err_d;
            idle_q  <= idle_d;
            stall_q <= stall_d;
        end
    end
    assign acomp       = acomp_q;
    assign out_valid   = cnt_q != 2'd0;
    assign out_bit     = out_valid & mem_q[rp_q];
    assign wf_count    = wf_q;
    assign err_illegal = err_q;
    assign stall       = stall_q;
`ifdef NCL_TAP_STATS_EN
    logic [15:0] per_q, per_d, min_q, min_d, max_q, max_d, meas;
    logic started_q, started_d;
    // meas is the push-to-push distance in clocks, counting the current edge.
    always_comb begin
        meas      = (per_q == 16'hFFFF) ? per_q : per_q + 16'd1;
        per_d     = push ? 16'd0 : meas;
        started_d = clr ? 1'b0 : started_q | push;
        min_d     = clr ? 16'hFFFF : (push && started_q && meas < min_q) ? meas : min_q;
        max_d     = clr ? 16'd0 : (push && started_q && meas > max_q) ? meas : max_q;
    end
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            per_q     <= 16'd0;
            started_q <= 1'b0;
            min_q     <= 16'hFFFF;
            max_q     <= 16'd0;
        end else begin
            per_q     <= per_d;
            started_q <= started_d;
            min_q     <= min_d;
            max_q     <= max_d;
        end
    end
    assign period_min = min_q;
    assign period_max = max_q;
`endif
endmodule
